key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_key_conditioner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-flop synchroniser, counter debounce, press/release/long-press pulses.
// Define KEY_REPEAT_EN to re-pulse key_press every REPEAT_CYCLES while a key stays held past long-press.
module key_conditioner #(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned DEB_CYCLES    = 2000000,
  parameter int unsigned LONG_CYCLES   = 100000000,
  parameter int unsigned REPEAT_CYCLES = 20000000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_held_long
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } key_state_t;

  localparam logic [63:0]      CNT_LIMIT = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (N_KEYS < 1 || N_KEYS > 8 || DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES ||
      64'(LONG_CYCLES) >= CNT_LIMIT || 64'(REPEAT_CYCLES) >= CNT_LIMIT) begin : g_bad_params
    $error("key_conditioner: illegal parameter combination");
  end

  logic [N_KEYS-1:0] sync_meta;
  logic [N_KEYS-1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= key_in;
      sync      <= sync_meta;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t       state;
    key_state_t       state_d;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] hold_inc;
    logic             level;
    logic             differ;
    logic             accept;
    logic             acc_press;
    logic             acc_release;
    logic             press_d;
    logic             release_d;
    logic             long_d;
    logic             press_q;
    logic             release_q;
    logic             long_q;
`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_d;
`endif

    // accept is the edge on which level toggles; the FSM consumes it directly so
    // the pulse lands in the same cycle as the new level.
    assign differ      = sync[k] ^ level;
    assign accept      = differ && (deb_cnt == DEB_LAST);
    assign acc_press   = accept & ~level;
    assign acc_release = accept & level;
    assign hold_inc    = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        deb_cnt <= '0;
        level   <= 1'b0;
      end else if (!differ) begin
        deb_cnt <= '0;
      end else if (accept) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end

    always_comb begin
      state_d   = state;
      hold_d    = hold_cnt;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_d     = rep_cnt;
`endif
      case (state)
        IDLE: begin
          if (acc_press) begin
            state_d = PRESSED;
            press_d = 1'b1;
            hold_d  = '0;
          end
        end
        PRESSED: begin
          if (acc_release) begin
            state_d   = IDLE;
            release_d = 1'b1;
            hold_d    = '0;
          end else begin
            hold_d = hold_inc;
            if (hold_cnt == LONG_LAST) begin
              state_d = LONG;
              long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end
        end
        LONG: begin
          if (acc_release) begin
            state_d   = IDLE;
            release_d = 1'b1;
            hold_d    = '0;
`ifdef KEY_REPEAT_EN
            rep_d     = '0;
`endif
          end else begin
            hold_d = hold_inc;
`ifdef KEY_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              press_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_cnt + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt   <= '0;
`endif
      end else begin
        state     <= state_d;
        hold_cnt  <= hold_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
`ifdef KEY_REPEAT_EN
        rep_cnt   <= rep_d;
`endif
      end
    end

    assign key_level[k]     = level;
    assign key_press[k]     = press_q;
    assign key_release[k]   = release_q;
    assign key_long[k]      = long_q;
    assign key_held_long[k] = (state == LONG);
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios with literal timing plus random key activity
// checked every cycle against a window-based behavioural model.
module tb_key_conditioner;

  localparam int NK    = 4;
  localparam int DEB   = 4;
  localparam int LONGC = 20;
  localparam int REP   = 8;
  localparam int CW    = 27;
  localparam int MAXC  = 8000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic [NK-1:0] key_held_long;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  key_conditioner #(
    .N_KEYS       (NK),
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONGC),
    .REPEAT_CYCLES(REP),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_long     (key_long),
    .key_held_long(key_held_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: sync is the raw input two edges late; a level flips once the last DEB
  // sync samples since the most recent reset all disagree with it.
  logic [NK-1:0] sync_at [MAXC];

  initial begin : model
    logic [NK-1:0] m_s1, m_s2, m_lvl, kin;
    logic [NK-1:0] e_press, e_rel, e_long, e_held;
    logic          rin;
    bit            on;
    bit            acc;
    int            last_rst;
    int            n;
    int            d;
    int            press_at [NK];
    on = 0;
    last_rst = 0;
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    e_press = '0; e_rel = '0; e_long = '0; e_held = '0;
    for (int k = 0; k < NK; k++) press_at[k] = 0;
    forever begin
      @(posedge clk);
      kin = key_in;
      rin = rst_n;
      n = cyc + 1;
      cyc = n;
      #1;
      if (n >= MAXC) begin
        $display("FAIL model_capacity: cycle %0d exceeds model history of %0d", n, MAXC);
        $fatal(1);
      end
      if (rin !== 1'b1) begin
        on = 1;
        last_rst = n;
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        e_press = '0; e_rel = '0; e_long = '0; e_held = '0;
      end else if (on) begin
        sync_at[n] = m_s2;
        e_press = '0; e_rel = '0; e_long = '0; e_held = '0;
        for (int k = 0; k < NK; k++) begin
          acc = 1'b1;
          for (int j = 0; j < DEB; j++)
            if (n - j <= last_rst || sync_at[n-j][k] == m_lvl[k]) acc = 1'b0;
          if (acc) begin
            m_lvl[k] = ~m_lvl[k];
            if (m_lvl[k]) begin
              press_at[k] = n;
              e_press[k]  = 1'b1;
            end else begin
              e_rel[k] = 1'b1;
            end
          end else if (m_lvl[k]) begin
            d = n - press_at[k];
            if (d == LONGC) e_long[k] = 1'b1;
`ifdef KEY_REPEAT_EN
            if (d > LONGC && ((d - LONGC) % REP) == 0) e_press[k] = 1'b1;
`endif
          end
          e_held[k] = m_lvl[k] && ((n - press_at[k]) >= LONGC);
        end
        m_s2 = m_s1;
        m_s1 = kin;
      end
      if (on) begin
        check("level",     key_level,     m_lvl);
        check("press",     key_press,     e_press);
        check("release",   key_release,   e_rel);
        check("long",      key_long,      e_long);
        check("held_long", key_held_long, e_held);
      end
    end
  end

  initial begin : stim
    int          remain [NK];
    int unsigned r;
    logic        exp_b;
    rst_n  = 1'b0;
    key_in = '0;

    // Reset with all keys held, then exit: everything accepted at t=6.
    @(negedge clk);
    key_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      check("reset_all_zero", {key_level, key_press, key_release, key_long, key_held_long}, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      edges(1);
      check("reset_exit_press_early", key_press, 4'b0000);
      check("reset_exit_level_early", key_level, 4'b0000);
    end
    edges(1);
    check("reset_exit_level_t6", key_level, 4'b1111);
    check("reset_exit_press_t6", key_press, 4'b1111);
    edges(1);
    check("reset_exit_press_t7", key_press, 4'b0000);
    @(negedge clk);
    key_in = '0;
    edges(12);

    // Bounce on key 0: 1,0,1,0 then steady 1.
    @(negedge clk); key_in[0] = 1'b1;
    @(negedge clk); key_in[0] = 1'b0;
    @(negedge clk); key_in[0] = 1'b1;
    @(negedge clk); key_in[0] = 1'b0;
    @(negedge clk); key_in[0] = 1'b1;
    edges(5);
    check("bounce_press_t5", key_press[0], 1'b0);
    check("bounce_level_t5", key_level[0], 1'b0);
    edges(1);
    check("bounce_press_t6", key_press[0], 1'b1);
    edges(1);
    check("bounce_press_t7", key_press[0], 1'b0);
    @(negedge clk);
    key_in[0] = 1'b0;
    edges(10);

    // Long press on key 1 for 40 cycles.
    @(negedge clk);
    key_in[1] = 1'b1;
    edges(6);
    check("long_press_t6", key_press[1], 1'b1);
    edges(19);
    check("long_long_t25", key_long[1], 1'b0);
    check("long_held_t25", key_held_long[1], 1'b0);
    edges(1);
    check("long_long_t26", key_long[1], 1'b1);
    check("long_held_t26", key_held_long[1], 1'b1);
    edges(1);
    check("long_long_t27", key_long[1], 1'b0);
    check("long_held_t27", key_held_long[1], 1'b1);
    edges(13);
    @(negedge clk);
    key_in[1] = 1'b0;
    edges(5);
    check("long_held_before_rel", key_held_long[1], 1'b1);
    check("long_rel_early", key_release[1], 1'b0);
    edges(1);
    check("long_rel_t6", key_release[1], 1'b1);
    check("long_held_after_rel", key_held_long[1], 1'b0);
    check("long_level_after_rel", key_level[1], 1'b0);
    edges(10);

    // Key 2 held 60 cycles: repeat pulses only when the feature is built in.
    @(negedge clk);
    key_in[2] = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      edges(1);
`ifdef KEY_REPEAT_EN
      exp_b = (t == 6 || t == 34 || t == 42 || t == 50 || t == 58);
`else
      exp_b = (t == 6);
`endif
      check("repeat_press2", key_press[2], exp_b);
      check("repeat_release2", key_release[2], (t == 66));
      if (t == 60) begin
        @(negedge clk);
        key_in[2] = 1'b0;
      end
    end
    edges(10);

    // Keys 0 and 3 together; key 3 released so its release lands on the long-press cycle.
    @(negedge clk);
    key_in = 4'b1001;
    edges(6);
    check("simul_press", key_press, 4'b1001);
    edges(14);
    @(negedge clk);
    key_in[3] = 1'b0;
    edges(5);
    check("simul_long_t25", key_long, 4'b0000);
    edges(1);
    check("simul_long_t26", key_long, 4'b0001);
    check("simul_rel_t26", key_release, 4'b1000);
    @(negedge clk);
    key_in[0] = 1'b0;
    edges(10);

    // One-cycle reset while key 1 is in LONG, key still held afterwards.
    @(negedge clk);
    key_in[1] = 1'b1;
    edges(30);
    check("midrst_held_before", key_held_long[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    edges(1);
    check("midrst_all_zero", {key_level, key_press, key_release, key_long, key_held_long}, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      edges(1);
      check("midrst_release", key_release, 4'b0000);
      check("midrst_press1", key_press[1], (t == 6));
      check("midrst_level1", key_level[1], (t >= 6));
    end
    @(negedge clk);
    key_in[1] = 1'b0;
    edges(10);

    // Random key activity: glitches, short and long holds, rare resets.
    for (int k = 0; k < NK; k++) remain[k] = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < NK; k++) begin
        if (remain[k] == 0) begin
          key_in[k] = ~key_in[k];
          r = $urandom_range(0, 9);
          if (r < 3)      remain[k] = int'($urandom_range(1, 3));
          else if (r < 6) remain[k] = int'($urandom_range(4, 15));
          else            remain[k] = int'($urandom_range(18, 45));
        end else begin
          remain[k]--;
        end
      end
    end
    @(negedge clk);
    rst_n  = 1'b1;
    key_in = '0;
    edges(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
